// File: rtl/rotor_stage.sv
// rotor_stage: one substitution rotor with ring setting, stepping/turnover and a 1-deep output register.
// Optional ROTOR_WIRING_LOAD_EN adds a write port for the wiring tables; undefined keeps them fixed.
module rotor_stage #(
  parameter int N_SYM    = 26,
  parameter int SYM_W    = 5,
  parameter int NOTCH    = 16,
  parameter int INIT_POS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SYM_W-1:0] in_sym,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] out_sym,
  input  logic             step,
  input  logic             pos_load,
  input  logic [SYM_W-1:0] pos_val,
  input  logic [SYM_W-1:0] ring_val,
  output logic [SYM_W-1:0] pos,
  output logic             at_notch,
  output logic             carry
`ifdef ROTOR_WIRING_LOAD_EN
  ,
  input  logic             wr_en,
  input  logic [SYM_W-1:0] wr_addr,
  input  logic [SYM_W-1:0] wr_data
`endif
);

  localparam int DEPTH = 2 ** SYM_W;
  localparam logic [SYM_W:0] NV = (SYM_W + 1)'(N_SYM);

  // Default wiring EKMFLGDQVZNTOWYHXUSPAIBRCJ; indices past the alphabet map to themselves.
  function automatic logic [SYM_W-1:0] wDefault(input int idx);
    int r;
    case (idx)
      0: r = 4;   1: r = 10;  2: r = 12;  3: r = 5;   4: r = 11;  5: r = 6;
      6: r = 3;   7: r = 16;  8: r = 21;  9: r = 25;  10: r = 13; 11: r = 19;
      12: r = 14; 13: r = 22; 14: r = 24; 15: r = 7;  16: r = 23; 17: r = 20;
      18: r = 18; 19: r = 15; 20: r = 0;  21: r = 8;  22: r = 1;  23: r = 17;
      24: r = 2;  25: r = 9;
      default: r = idx;
    endcase
    return SYM_W'(r);
  endfunction

  function automatic logic [SYM_W-1:0] winvDefault(input int idx);
    int r;
    case (idx)
      0: r = 20;  1: r = 22;  2: r = 24;  3: r = 6;   4: r = 0;   5: r = 3;
      6: r = 5;   7: r = 15;  8: r = 21;  9: r = 25;  10: r = 1;  11: r = 4;
      12: r = 2;  13: r = 10; 14: r = 12; 15: r = 19; 16: r = 7;  17: r = 23;
      18: r = 18; 19: r = 11; 20: r = 17; 21: r = 8;  22: r = 13; 23: r = 16;
      24: r = 14; 25: r = 9;
      default: r = idx;
    endcase
    return SYM_W'(r);
  endfunction

  // Operands are below N_SYM, so one conditional correction keeps results in range.
  function automatic logic [SYM_W:0] modAdd(input logic [SYM_W:0] a, input logic [SYM_W:0] b);
    logic [SYM_W:0] s;
    s = a + b;
    if (s >= NV) s = s - NV;
    return s;
  endfunction

  function automatic logic [SYM_W:0] modSub(input logic [SYM_W:0] a, input logic [SYM_W:0] b);
    if (a >= b) return a - b;
    return a + NV - b;
  endfunction

  logic             valid_q, valid_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [SYM_W-1:0] pos_q, pos_d;
  logic [SYM_W-1:0] ring_q, ring_d;
  logic             carry_q, carry_d;

  logic [SYM_W:0]   entryIdx;
  logic [SYM_W-1:0] tabIdx;
  logic [SYM_W-1:0] wRead, winvRead, tabVal;
  logic [SYM_W:0]   exitSum;
  logic [SYM_W-1:0] xlated;
  logic             accept;
  logic             unusedBits;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_sym   = sym_q;
  assign pos       = pos_q;
  assign at_notch  = (pos_q == SYM_W'(NOTCH));
  assign carry     = carry_q;

`ifdef ROTOR_WIRING_LOAD_EN
  logic [SYM_W-1:0] w_q    [DEPTH];
  logic [SYM_W-1:0] winv_q [DEPTH];
  logic             wrOk;

  assign wrOk = wr_en && ({1'b0, wr_addr} < NV) && ({1'b0, wr_data} < NV);

  // Forward and inverse entries are written together so the pair stays consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_q[i]    <= wDefault(i);
        winv_q[i] <= winvDefault(i);
      end
    end else if (wrOk) begin
      w_q[wr_addr]    <= wr_data;
      winv_q[wr_data] <= wr_addr;
    end
  end

  assign wRead    = w_q[tabIdx];
  assign winvRead = winv_q[tabIdx];
`else
  assign wRead    = wDefault(int'(tabIdx));
  assign winvRead = winvDefault(int'(tabIdx));
`endif

  assign entryIdx = modSub(modAdd({1'b0, in_sym}, {1'b0, pos_q}), {1'b0, ring_q});
  assign tabIdx   = entryIdx[SYM_W-1:0];
  assign tabVal   = in_dir ? winvRead : wRead;
  assign exitSum  = modSub(modAdd({1'b0, tabVal}, {1'b0, ring_q}), {1'b0, pos_q});
  assign xlated   = ({1'b0, in_sym} >= NV) ? in_sym : exitSum[SYM_W-1:0];

  assign unusedBits = ^{entryIdx[SYM_W], exitSum[SYM_W]};

  // Translation uses the current pos/ring, so a coincident step or load affects only later symbols.
  always_comb begin
    valid_d = valid_q;
    sym_d   = sym_q;
    pos_d   = pos_q;
    ring_d  = ring_q;
    carry_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      sym_d   = xlated;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    if (pos_load) begin
      pos_d  = pos_val;
      ring_d = ring_val;
    end else if (step) begin
      pos_d   = (pos_q == SYM_W'(N_SYM - 1)) ? '0 : pos_q + 1'b1;
      carry_d = at_notch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sym_q   <= '0;
      pos_q   <= SYM_W'(INIT_POS);
      ring_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sym_q   <= sym_d;
      pos_q   <= pos_d;
      ring_q  <= ring_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_rotor_stage.sv
// Self-checking bench for rotor_stage: vector table, hand-written corner sequences and a random run
// against an arithmetic reference model. Define ROTOR_WIRING_LOAD_EN to also exercise table writes.
module tb_rotor_stage;

  localparam int N = 26;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sym;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sym;
  logic          step;
  logic          pos_load;
  logic [SW-1:0] pos_val;
  logic [SW-1:0] ring_val;
  logic [SW-1:0] pos;
  logic          at_notch;
  logic          carry;
`ifdef ROTOR_WIRING_LOAD_EN
  logic          wr_en;
  logic [SW-1:0] wr_addr;
  logic [SW-1:0] wr_data;
`endif

  rotor_stage #(.N_SYM(N), .SYM_W(SW), .NOTCH(16), .INIT_POS(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .step(step), .pos_load(pos_load), .pos_val(pos_val), .ring_val(ring_val),
    .pos(pos), .at_notch(at_notch), .carry(carry)
`ifdef ROTOR_WIRING_LOAD_EN
    , .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`endif
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  int wModel[N];
  int winvModel[N];

  typedef struct {
    int posV;
    int ringV;
    bit dir;
    int sym;
    int expected;
  } vec_t;

  vec_t vecs[6];

  int mPos, mRing, mValid, mSym, mCarry;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit iv, input int sym, input bit dir, input bit ordy,
                               input bit stp, input bit ld, input int pv, input int rv);
    in_valid  = iv;
    in_sym    = SW'(sym);
    in_dir    = dir;
    out_ready = ordy;
    step      = stp;
    pos_load  = ld;
    pos_val   = SW'(pv);
    ring_val  = SW'(rv);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic loadPos(input int p, input int r);
    applyStimulus(0, 0, 0, 1, 0, 1, p, r);
    @(negedge clk);
    idle();
  endtask

  function automatic int modelTranslate(input int sym, input int dir, input int p, input int r);
    int c, t;
    if (sym >= N) return sym;
    c = (sym + p - r + 2 * N) % N;
    t = dir ? winvModel[c] : wModel[c];
    return (t - p + r + 2 * N) % N;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string wiring;
    wiring = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    for (int i = 0; i < N; i++) wModel[i] = int'(wiring[i]) - 65;
    for (int i = 0; i < N; i++) winvModel[wModel[i]] = i;

    vecs[0] = '{posV: 0,  ringV: 0, dir: 0, sym: 0,  expected: 4};
    vecs[1] = '{posV: 0,  ringV: 0, dir: 1, sym: 4,  expected: 0};
    vecs[2] = '{posV: 1,  ringV: 0, dir: 0, sym: 0,  expected: 9};
    vecs[3] = '{posV: 0,  ringV: 1, dir: 0, sym: 0,  expected: 10};
    vecs[4] = '{posV: 25, ringV: 0, dir: 0, sym: 1,  expected: 5};
    vecs[5] = '{posV: 2,  ringV: 3, dir: 1, sym: 10, expected: 0};

`ifdef ROTOR_WIRING_LOAD_EN
    wr_en = 0; wr_addr = 0; wr_data = 0;
`endif
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.pos", pos, 0);
    checkOutput("rst.outValid", out_valid, 0);
    checkOutput("rst.outSym", out_sym, 0);
    checkOutput("rst.carry", carry, 0);
    checkOutput("rst.inReady", in_ready, 1);
    checkOutput("rst.atNotch", at_notch, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      loadPos(vecs[i].posV, vecs[i].ringV);
      checkOutput($sformatf("vec%0d.pos", i), pos, vecs[i].posV);
      applyStimulus(1, vecs[i].sym, vecs[i].dir, 1, 0, 0, 0, 0);
      @(negedge clk);
      idle();
      checkOutput($sformatf("vec%0d.valid", i), out_valid, 1);
      checkOutput($sformatf("vec%0d.sym", i), out_sym, vecs[i].expected);
      @(negedge clk);
    end

    loadPos(3, 0);
    applyStimulus(1, 30, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("passthru.sym", out_sym, 30);
    @(negedge clk);

    // Turnover from the notch position
    loadPos(16, 0);
    checkOutput("notch.atNotch", at_notch, 1);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("notch.pos", pos, 17);
    checkOutput("notch.atNotchAfter", at_notch, 0);
    checkOutput("notch.carry", carry, 1);
    @(negedge clk);
    checkOutput("notch.carryPulse", carry, 0);

    loadPos(25, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("wrap.pos", pos, 0);
    checkOutput("wrap.carry", carry, 0);

    loadPos(16, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 5, 0);
    @(negedge clk);
    idle();
    checkOutput("loadPrio.pos", pos, 5);
    checkOutput("loadPrio.carry", carry, 0);

    loadPos(0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("stepAccept.sym", out_sym, 4);
    checkOutput("stepAccept.pos", pos, 1);
    @(negedge clk);

    // Backpressure: output must hold and the stage must refuse new input
    loadPos(0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("stall%0d.valid", k), out_valid, 1);
      checkOutput($sformatf("stall%0d.sym", k), out_sym, 4);
      checkOutput($sformatf("stall%0d.inReady", k), in_ready, 0);
      @(negedge clk);
    end
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
    #1;
    checkOutput("release.inReady", in_ready, 1);
    @(negedge clk);
    idle();
    checkOutput("release.valid", out_valid, 1);
    checkOutput("release.sym", out_sym, 10);
    @(negedge clk);
    checkOutput("drain.valid", out_valid, 0);

    // Asynchronous reset while an output is pending
    loadPos(7, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("preRst.valid", out_valid, 1);
    checkOutput("preRst.pos", pos, 7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst.valid", out_valid, 0);
    checkOutput("asyncRst.pos", pos, 0);
    checkOutput("asyncRst.sym", out_sym, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("postRst.inReady", in_ready, 1);
    @(negedge clk);

    mPos = 0; mRing = 0; mValid = 0; mSym = 0; mCarry = 0;
    for (int it = 0; it < 400; it++) begin
      bit iv, dir, ordy, stp, ld;
      int sym, pv, rv, mReady;
      checkOutput($sformatf("rnd%0d.valid", it), out_valid, mValid);
      if (mValid != 0) checkOutput($sformatf("rnd%0d.sym", it), out_sym, mSym);
      checkOutput($sformatf("rnd%0d.pos", it), pos, mPos);
      checkOutput($sformatf("rnd%0d.carry", it), carry, mCarry);
      checkOutput($sformatf("rnd%0d.atNotch", it), at_notch, (mPos == 16) ? 1 : 0);

      iv   = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      stp  = ($urandom_range(0, 2) == 0);
      ld   = ($urandom_range(0, 7) == 0);
      sym  = int'($urandom_range(0, 31));
      pv   = ($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(0, N - 1));
      rv   = int'($urandom_range(0, N - 1));
      applyStimulus(iv, sym, dir, ordy, stp, ld, pv, rv);
      #1;
      mReady = (mValid == 0 || ordy) ? 1 : 0;
      checkOutput($sformatf("rnd%0d.inReady", it), in_ready, mReady);

      if (iv && mReady != 0) begin
        mValid = 1;
        mSym = modelTranslate(sym, dir, mPos, mRing);
      end else if (ordy) begin
        mValid = 0;
      end
      mCarry = 0;
      if (ld) begin
        mPos = pv;
        mRing = rv;
      end else if (stp) begin
        mCarry = (mPos == 16) ? 1 : 0;
        mPos = (mPos + 1) % N;
      end
      @(negedge clk);
    end
    idle();
    @(negedge clk);

`ifdef ROTOR_WIRING_LOAD_EN
    loadPos(0, 0);
    wr_en = 1; wr_addr = 0; wr_data = 0;
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("wrOld.sym", out_sym, 4);
    wr_addr = 4; wr_data = 4;
    @(negedge clk);
    wr_addr = 0; wr_data = 30;
    @(negedge clk);
    wr_en = 0;
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("wrNew.fwd", out_sym, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("wrNew.rev", out_sym, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    idle();
    checkOutput("wrKeep.fwd", out_sym, 10);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rotor_stage.md
ROTOR_STAGE -- requirements
Module: rotor_stage

Interface
REQ-001 SHALL have parameter N_SYM, default 26: alphabet size, 2..(2^SYM_W).
REQ-002 SHALL have parameter SYM_W, default 5: symbol/position width.
REQ-003 SHALL have parameter NOTCH, default 16 (Q): turnover position.
REQ-004 SHALL have parameter INIT_POS, default 0: position after reset.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  in  1  input symbol valid.
REQ-008 SHALL have port in_ready  out  1  stage accepts input.
REQ-009 SHALL have port in_sym  in  SYM_W  input symbol index.
REQ-010 SHALL have port in_dir  in  1  0 = forward (entry->reflector), 1 = reverse.
REQ-011 SHALL have port out_valid  out  1  output symbol valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts output.
REQ-013 SHALL have port out_sym  out  SYM_W  translated symbol.
REQ-014 SHALL have port step  in  1  advance position by one this cycle.
REQ-015 SHALL have port pos_load  in  1  load pos_val and ring_val.
REQ-016 SHALL have ports pos_val / ring_val  in  SYM_W each  new position / ring setting.
REQ-017 SHALL have port pos  out  SYM_W  current position.
REQ-018 SHALL have port at_notch  out  1  pos == NOTCH (combinational, for double-step).
REQ-019 SHALL have port carry  out  1  one-cycle pulse: step taken from NOTCH.

Function
REQ-020 SHALL set in_ready = !out_valid || out_ready; accept on in_valid && in_ready.
REQ-021 SHALL register the result on accept: out_valid and out_sym valid the next cycle (latency 1); without a new accept, out_valid clears when out_ready=1.
REQ-022 SHALL hold out_sym and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL compute forward: c = (in_sym + pos - ring) mod N_SYM; out_sym = (W[c] - pos + ring) mod N_SYM.
REQ-024 SHALL compute reverse identically using the inverse table Winv in place of W.
REQ-025 SHALL do all modular arithmetic in SYM_W+1 bits with conditional add/subtract of N_SYM; no divide.
REQ-026 SHALL pass through in_sym unchanged when in_sym >= N_SYM.
REQ-027 SHALL, on step, set pos = pos+1, wrapping N_SYM-1 -> 0; carry=1 next cycle iff old pos == NOTCH.
REQ-028 SHALL give pos_load priority over step in the same cycle; no carry on load.
REQ-029 SHALL translate an accept coincident with step or pos_load using the pre-update pos/ring.
REQ-030 SHALL have default W = EKMFLGDQVZNTOWYHXUSPAIBRCJ (A=0: 4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9) and Winv its exact inverse.

Reset
REQ-031 SHALL on rst_n low, immediately: pos=INIT_POS, ring=0, out_valid=0, out_sym=0, carry=0, W/Winv=default.
REQ-032 SHALL drop any in-flight output on reset mid-transfer; in_ready=1 after release.

Configuration
REQ-033 SHALL, with ROTOR_WIRING_LOAD_EN defined, add inputs wr_en (1), wr_addr (SYM_W), wr_data (SYM_W); wr_en writes W[wr_addr]=wr_data and Winv[wr_data]=wr_addr, effective next cycle; an accept in the write cycle uses the old table; wr_addr or wr_data >= N_SYM ignored.
REQ-034 SHALL, without ROTOR_WIRING_LOAD_EN, omit those ports and hold W/Winv constant at default.

Verification
REQ-035 SHALL check pos=0, ring=0: fwd in_sym=0 -> out_sym=4; rev in_sym=4 -> out_sym=0.
REQ-036 SHALL check pos_load pos=1, ring=0: fwd 0 -> 9; pos=0, ring=1: fwd 0 -> 10.
REQ-037 SHALL check pos=16, step -> pos=17, at_notch 1->0, carry pulses 1 cycle; pos=25, step -> pos=0, no carry.
REQ-038 SHALL check out_ready=0 for 3 cycles after accept: out_valid=1, out_sym stable, in_ready=0; second symbol accepted only after out_ready=1.
REQ-039 SHALL check rst_n pulsed low with out_valid=1, pos=7: out_valid=0, pos=0 asynchronously.
REQ-040 SHALL check (macro on) write W[0]=0, W[4]=4 (with matching Winv updates), pos=0: fwd 0 -> 0, rev 0 -> 0.
